alu_divider_seq: RTL and testbench
==================================

# alu_divider_seq

Multi-cycle 32-bit integer divider for the MCU datapath. It is the inverse of the ALU's combinational 16-bit Booth multiplier. It computes quotient and remainder with a radix-2 restoring algorithm, one quotient bit per clock. The controller launches it with a start/done handshake and stalls until `done`; results feed the register-file write-back mux next to `ALU_result`.

## Interface
- `WIDTH`, 32: operand/result width in bits (≥ 4).
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `start`  in  1: request; sampled only in IDLE.
- `is_signed`  in  1: 1 = two's-complement divide, 0 = unsigned; sampled with `start`.
- `A`  in  WIDTH: dividend; sampled with `start`.
- `B`  in  WIDTH: divisor; sampled with `start`.
- `busy`  out  1: high from the cycle after accept until `done`, inclusive.
- `done`  out  1: one-cycle pulse; results valid from this cycle on.
- `quotient`  out  WIDTH: quotient, held until next accept.
- `remainder`  out  WIDTH: remainder, held until next accept.
- `DZ`  out  1: divide-by-zero flag, valid with `done`, held.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start`=1 captures operands.
  - If B==0 → DONE with `quotient`=all ones, `remainder`=A, `DZ`=1.
  - If `is_signed` and A==most-negative and B==all ones → DONE with `quotient`=A, `remainder`=0, `DZ`=0 (signed overflow, no trap).
  - Otherwise, load |A| and |B| (magnitudes only when `is_signed`), latch sign_q = sign(A)^sign(B) and sign_r = sign(A), clear the partial remainder, set the bit counter to WIDTH−1, and go to CALC.
- CALC, one step per cycle:
  - Shift {rem, dividend} left by 1 and form trial = rem − divisor (WIDTH+1-bit subtract).
  - If trial ≥ 0: rem ← trial and quotient bit = 1; else rem unchanged and quotient bit = 0.
  - After the step with counter==0, go to FIX.
- FIX:
  - Negate the quotient if sign_q; negate the remainder if sign_r.
  - Register the results, go to DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE unconditionally.
- Result rules:
  - Remainder takes the sign of the dividend.
  - Quotient truncates toward zero.
  - |remainder| < |divisor|.
- `start` while not in IDLE is ignored, with no queuing. `start` in the DONE cycle is also ignored; it is accepted only in the following IDLE cycle.
- Unsigned mode with operand MSB=1 is a full-range unsigned divide; no magnitude conversion is applied.

## Timing
- Accept edge = rising edge at which IDLE && `start`.
- Normal path: CALC occupies WIDTH cycles, then FIX for 1 and DONE for 1. `done` is high in cycle WIDTH+2 after the accept edge, which is 34 for WIDTH=32.
- Special cases (B==0, signed overflow): `done` is high in the first cycle after the accept edge.
- `busy` is high in every cycle after the accept edge up to and including the `done` cycle. It is low in IDLE.
- Back-to-back issue: minimum start-to-start spacing is WIDTH+3 cycles on the normal path.
- Reset values: state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `DZ`=0.
- `rst_n` low mid-operation aborts immediately (asynchronous). No `done` is issued for the aborted op, and outputs return to their reset values.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `alu_pkg`:
  - state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIX=2'd2, ST_DONE=2'd3;
  - DIV_WIDTH=32;
  - DZ quotient constant (all ones).
- One sub-module, `div_step`: combinational single restoring step with inputs rem, next dividend bit and divisor, and outputs new rem and quotient bit. The top holds the FSM, counter, sign handling and output registers.
- Counter width: $clog2(WIDTH).

## Test plan
- Unsigned: A=100, B=7, is_signed=0 → done at cycle 34, quotient=14, remainder=2, DZ=0, busy high cycles 1–34.
- Signed: A=−100 (0xFFFFFF9C), B=7 → quotient=−14 (0xFFFFFFF2), remainder=−2 (0xFFFFFFFE). A=100, B=−7 → quotient=−14, remainder=2.
- Divide by zero: A=0x12345678, B=0 → done at cycle 1, quotient=0xFFFFFFFF, remainder=0x12345678, DZ=1.
- Signed overflow: A=0x80000000, B=0xFFFFFFFF, is_signed=1 → done at cycle 1, quotient=0x80000000, remainder=0. The same operands unsigned → quotient=0, remainder=0x80000000 after 34 cycles.
- Handshake: start pulsed at cycles 5 and 20 of an active op, and in its DONE cycle → all ignored, a single done pulse, results unchanged. A new start in the next IDLE cycle is accepted.
- Reset mid-op: rst_n low at cycle 10 of A=1000, B=3 → busy/done/quotient/remainder/DZ go to 0 immediately. After release, a fresh A=1000, B=3 yields quotient=333, remainder=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential integer divider: FSM state encoding,
// default datapath width and the divide-by-zero quotient pattern.
package alu_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DZ_QUOT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/alu_divider_seq_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only when non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {i_rem, i_bit};
    assign w_trial = w_shift - {1'b0, i_dvs};

    // Restore on a negative trial; the partial remainder is always below the divisor.
    always_comb begin
        o_rem = w_shift[WIDTH-1:0];
        o_q   = 1'b0;
        if (w_trial[WIDTH] == 1'b0) begin
            o_rem = w_trial[WIDTH-1:0];
            o_q   = 1'b1;
        end else begin
            o_rem = w_shift[WIDTH-1:0];
            o_q   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_divider_seq.sv
// Multi-cycle signed/unsigned divider: magnitude restoring division, one
// quotient bit per clock, sign fix-up, with start/done handshake.
module alu_divider_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             DZ
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_dvd, w_dvd_nxt;
    logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
    logic [WIDTH-1:0] r_quot, w_quot_nxt;
    logic [WIDTH-1:0] r_rem_out, w_rem_out_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_sign_q, w_sign_q_nxt;
    logic             r_sign_r, w_sign_r_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_dz, w_dz_nxt;

    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;
    logic             w_a_neg, w_b_neg, w_ovf;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_a_neg = is_signed & A[WIDTH-1];
    assign w_b_neg = is_signed & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? -A : A;
    assign w_b_mag = w_b_neg ? -B : B;
    assign w_ovf   = is_signed && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == {WIDTH{1'b1}});

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[WIDTH-1]),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rem     <= {WIDTH{1'b0}};
            r_dvd     <= {WIDTH{1'b0}};
            r_dvs     <= {WIDTH{1'b0}};
            r_quot    <= {WIDTH{1'b0}};
            r_rem_out <= {WIDTH{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_dvd     <= w_dvd_nxt;
            r_dvs     <= w_dvs_nxt;
            r_quot    <= w_quot_nxt;
            r_rem_out <= w_rem_out_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sign_q  <= w_sign_q_nxt;
            r_sign_r  <= w_sign_r_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_dz      <= w_dz_nxt;
        end
    end

    // Next-state and datapath updates; r_dvd shifts out dividend bits and shifts in quotient bits.
    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_dvd_nxt     = r_dvd;
        w_dvs_nxt     = r_dvs;
        w_quot_nxt    = r_quot;
        w_rem_out_nxt = r_rem_out;
        w_cnt_nxt     = r_cnt;
        w_sign_q_nxt  = r_sign_q;
        w_sign_r_nxt  = r_sign_r;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_dz_nxt      = r_dz;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    if (B == {WIDTH{1'b0}}) begin
                        w_state_nxt   = ST_DONE;
                        w_quot_nxt    = WIDTH'(DZ_QUOT);
                        w_rem_out_nxt = A;
                        w_dz_nxt      = 1'b1;
                        w_done_nxt    = 1'b1;
                    end else if (w_ovf) begin
                        w_state_nxt   = ST_DONE;
                        w_quot_nxt    = A;
                        w_rem_out_nxt = {WIDTH{1'b0}};
                        w_dz_nxt      = 1'b0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_state_nxt  = ST_CALC;
                        w_rem_nxt    = {WIDTH{1'b0}};
                        w_dvd_nxt    = w_a_mag;
                        w_dvs_nxt    = w_b_mag;
                        w_sign_q_nxt = w_a_neg ^ w_b_neg;
                        w_sign_r_nxt = w_a_neg;
                        w_cnt_nxt    = CW'(WIDTH - 1);
                    end
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            ST_CALC: begin
                w_rem_nxt = w_step_rem;
                w_dvd_nxt = {r_dvd[WIDTH-2:0], w_step_q};
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == {CW{1'b0}}) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_FIX: begin
                w_quot_nxt    = r_sign_q ? -r_dvd : r_dvd;
                w_rem_out_nxt = r_sign_r ? -r_rem : r_rem;
                w_dz_nxt      = 1'b0;
                w_done_nxt    = 1'b1;
                w_state_nxt   = ST_DONE;
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem_out;
    assign DZ        = r_dz;

endmodule

// File: tb/tb_alu_divider_seq.sv
// Randomized and directed checks of alu_divider_seq against an arithmetic
// reference model (SV division/modulo semantics).
module tb_alu_divider_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        DZ;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_divider_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .DZ        (DZ)
    );

    // Reference: behaviour defined by ordinary integer division rules.
    task automatic model_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                             output logic [31:0] q, output logic [31:0] r,
                             output logic dz, output int lat);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        lat = 34;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; lat = 1;
        end else if (s) begin
            q = 32'(sa / sb); r = 32'(sa % sb);
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Issue one op and observe it; done_cyc stays 0 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r, output logic dz,
                          output int done_cyc, output logic busy_ok, output logic idle_ok);
        @(negedge clk);
        A = a; B = b; is_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = 0; busy_ok = 1'b1; idle_ok = 1'b0;
        q = 32'd0; r = 32'd0; dz = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                done_cyc = k; q = quotient; r = remainder; dz = DZ;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        idle_ok = (done === 1'b0) && (busy === 1'b0) && (quotient === q) && (remainder === r);
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        logic [31:0] q, r, eq, er;
        logic dz, edz, bok, iok;
        int cyc, ecyc;
        model_div(a, b, s, eq, er, edz, ecyc);
        run_op(a, b, s, q, r, dz, cyc, bok, iok);
        n_vec += 6;
        if (q !== eq) begin n_fail++; $display("FAIL %s quotient a=%h b=%h s=%0d got %h exp %h", name, a, b, s, q, eq); end
        if (r !== er) begin n_fail++; $display("FAIL %s remainder a=%h b=%h s=%0d got %h exp %h", name, a, b, s, r, er); end
        if (dz !== edz) begin n_fail++; $display("FAIL %s DZ a=%h b=%h got %0d exp %0d", name, a, b, dz, edz); end
        if (cyc !== ecyc) begin n_fail++; $display("FAIL %s done_cycle a=%h b=%h got %0d exp %0d", name, a, b, cyc, ecyc); end
        if (bok !== 1'b1) begin n_fail++; $display("FAIL %s busy_window got %0d exp 1", name, bok); end
        if (iok !== 1'b1) begin n_fail++; $display("FAIL %s post_done_idle got %0d exp 1", name, iok); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({busy, done, DZ} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%0d done=%0d dz=%0d q=%h r=%h exp all 0", busy, done, DZ, quotient, remainder);
        end
    endtask

    task automatic test_directed();
        check_op("udiv_100_7", 32'd100, 32'd7, 1'b0);
        check_op("sdiv_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1);
        check_op("sdiv_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1);
        check_op("div_zero", 32'h1234_5678, 32'd0, 1'b0);
        check_op("div_zero_s", 32'h8765_4321, 32'd0, 1'b1);
        check_op("s_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_op("u_overflow_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_op("u_full_range", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        check_op("div_by_one", 32'hDEAD_BEEF, 32'd1, 1'b0);
        check_op("s_neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(1, 15));
                1: b = $urandom;
                2: b = (i % 8 == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
                default: b = -32'($urandom_range(1, 300));
            endcase
            s = 1'($urandom_range(0, 1));
            check_op("random", a, b, s);
        end
    endtask

    task automatic test_handshake();
        int n_done, cyc2;
        logic q_ok, idle_ok, busy_ok;
        n_done = 0; cyc2 = 0; q_ok = 1'b0; idle_ok = 1'b0; busy_ok = 1'b1;
        @(negedge clk);
        A = 32'd100; B = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            if (k <= 35 && done === 1'b1) n_done++;
            if (k <= 34 && busy !== 1'b1) busy_ok = 1'b0;
            if (k == 34) q_ok = (done === 1'b1) && (quotient === 32'd14) && (remainder === 32'd2) && (DZ === 1'b0);
            if (k == 35) idle_ok = (busy === 1'b0) && (done === 1'b0) && (quotient === 32'd14) && (remainder === 32'd2);
            if (k > 35 && done === 1'b1 && cyc2 == 0) begin
                cyc2 = k - 35;
                n_vec++;
                if (quotient !== 32'd28 || remainder !== 32'd4) begin
                    n_fail++;
                    $display("FAIL hs_second_result got q=%0d r=%0d exp q=28 r=4", quotient, remainder);
                end
            end
            start = 1'b0;
            if (k == 5 || k == 20 || k == 34) begin
                A = 32'd5; B = 32'd0; is_signed = 1'b1; start = 1'b1;
            end else if (k == 35) begin
                A = 32'd200; B = 32'd7; is_signed = 1'b0; start = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_vec += 5;
        if (n_done !== 1) begin n_fail++; $display("FAIL hs_single_done got %0d pulses exp 1", n_done); end
        if (q_ok !== 1'b1) begin n_fail++; $display("FAIL hs_first_result got %0d exp 1", q_ok); end
        if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL hs_idle_after_done got %0d exp 1", idle_ok); end
        if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL hs_busy_window got %0d exp 1", busy_ok); end
        if (cyc2 !== 34) begin n_fail++; $display("FAIL hs_second_accept done_cycle got %0d exp 34", cyc2); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        A = 32'd1000; B = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, DZ} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid got busy=%0d done=%0d dz=%0d q=%h r=%h exp all 0", busy, done, DZ, quotient, remainder);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got busy=%0d done=%0d exp 0 0", busy, done);
        end
        check_op("after_reset", 32'd1000, 32'd3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
